uart_dump_sequencer: RTL and testbench

Sequences the read-out of a captured PSRAM sample window to the host over UART. On a start pulse it walks a contiguous PSRAM address range: it issues one 16-bit read per address, waits for the data, and hands the word to the UART transmitter as one 2-byte frame. It waits for that frame to finish before moving to the next address. It sits between the PSRAM controller read port and the UART transmit interface (`send_uart` / `send_msg`), and is started by top-level logic once an acquisition completes.

---
 rtl/uart_dump_sequencer_if.sv | 40 ++++
 rtl/uart_dump_sequencer.sv | 132 +++++++++++++
 tb/tb_uart_dump_sequencer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_dump_sequencer_if.sv
// Bundle between the dump sequencer and its neighbours: control/status from
// top-level logic, the PSRAM read port and the UART transmit handshake.
interface uart_dump_sequencer_if #(
  parameter int unsigned CNT_W = 24
);
  localparam int unsigned ADDR_W = 23;
  localparam int unsigned DATA_W = 16;

  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] base_address;
  logic [CNT_W-1:0]  word_count;
  logic              busy;
  logic              done;
  logic              error;
  logic [CNT_W-1:0]  words_sent;

  logic              read_req;
  logic [ADDR_W-1:0] read_address;
  logic              read_valid;
  logic [DATA_W-1:0] read_data;

  logic              send_uart;
  logic [DATA_W-1:0] send_msg;
  logic              tx_busy;

  modport master (
    input  start, abort, base_address, word_count,
    input  read_valid, read_data, tx_busy,
    output busy, done, error, words_sent,
    output read_req, read_address, send_uart, send_msg
  );

  modport slave (
    output start, abort, base_address, word_count,
    output read_valid, read_data, tx_busy,
    input  busy, done, error, words_sent,
    input  read_req, read_address, send_uart, send_msg
  );
endinterface

// File: rtl/uart_dump_sequencer.sv
// Walks a PSRAM address range, reading one word per address and sending each
// word as a 2-byte UART frame; waits for every frame to finish before moving on.
module uart_dump_sequencer #(
  parameter int unsigned READ_TIMEOUT = 1023,
  parameter int unsigned CNT_W        = 24
) (
  input logic                  clk_PSRAM,
  input logic                  reset,
  uart_dump_sequencer_if.master bus
);
  localparam int unsigned ADDR_W = 23;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned TMR_W  = $clog2(READ_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT_DATA, SEND, WAIT_TX_HI, WAIT_TX_LO, NEXT, FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [CNT_W-1:0]  remain_q, remain_d;
  logic [CNT_W-1:0]  sent_q, sent_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] msg_q, msg_d;
  logic              req_q, req_d;
  logic              send_q, send_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              timeout;

  // Timer is 1 in the first WAIT_DATA cycle, so read_req spans READ_TIMEOUT cycles including REQ.
  assign timeout = (tmr_q >= TMR_W'(READ_TIMEOUT - 1));

  always_ff @(posedge clk_PSRAM) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (bus.start) state_d = (bus.word_count != '0) ? REQ : FINISH;
      REQ:        state_d = WAIT_DATA;
      WAIT_DATA: begin
        if (bus.read_valid) state_d = SEND;
        else if (timeout)   state_d = FINISH;
      end
      SEND:       if (!bus.tx_busy) state_d = WAIT_TX_HI;
      WAIT_TX_HI: if (bus.tx_busy)  state_d = WAIT_TX_LO;
      WAIT_TX_LO: if (!bus.tx_busy) state_d = NEXT;
      NEXT:       state_d = ((remain_q == '0) || bus.abort) ? FINISH : REQ;
      FINISH:     state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Next values for every registered output and the datapath.
  always_comb begin
    tmr_d    = tmr_q;
    remain_d = remain_q;
    sent_d   = sent_q;
    addr_d   = addr_q;
    msg_d    = msg_q;
    err_d    = err_q;
    req_d    = (state_d == REQ) || (state_d == WAIT_DATA);
    send_d   = (state_q == SEND) && !bus.tx_busy;
    busy_d   = (state_q != IDLE);
    done_d   = (state_q == FINISH);
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sent_d = '0;
          err_d  = 1'b0;
          if (bus.word_count != '0) begin
            addr_d   = bus.base_address;
            remain_d = bus.word_count;
          end
        end
      end
      REQ:       tmr_d = TMR_W'(1);
      WAIT_DATA: begin
        if (bus.read_valid) msg_d = bus.read_data;
        else if (timeout)   err_d = 1'b1;
        else                tmr_d = tmr_q + TMR_W'(1);
      end
      WAIT_TX_LO: begin
        if (!bus.tx_busy) begin
          sent_d   = sent_q + CNT_W'(1);
          remain_d = remain_q - CNT_W'(1);
        end
      end
      NEXT:    addr_d = addr_q + ADDR_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk_PSRAM) begin
    if (reset) begin
      tmr_q    <= '0;
      remain_q <= '0;
      sent_q   <= '0;
      addr_q   <= '0;
      msg_q    <= '0;
      req_q    <= 1'b0;
      send_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      tmr_q    <= tmr_d;
      remain_q <= remain_d;
      sent_q   <= sent_d;
      addr_q   <= addr_d;
      msg_q    <= msg_d;
      req_q    <= req_d;
      send_q   <= send_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.read_req     = req_q;
  assign bus.read_address = addr_q;
  assign bus.send_uart    = send_q;
  assign bus.send_msg     = msg_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.error        = err_q;
  assign bus.words_sent   = sent_q;
endmodule

// File: tb/tb_uart_dump_sequencer.sv
// Scoreboard bench for uart_dump_sequencer: PSRAM and UART models, expected
// read addresses and frame words queued per dump, checked by a monitor.
module tb_uart_dump_sequencer;
  localparam int unsigned CNT_W = 24;
  localparam int unsigned RT    = 16;

  logic clk;
  logic reset;

  uart_dump_sequencer_if #(.CNT_W(CNT_W)) bus ();

  uart_dump_sequencer #(.READ_TIMEOUT(RT), .CNT_W(CNT_W)) dut (
    .clk_PSRAM (clk),
    .reset     (reset),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned send_cnt = 0;
  int unsigned done_cnt = 0;
  int unsigned psram_lat = 4;
  int unsigned uart_dur = 20;
  bit          psram_mute = 1'b0;
  logic [15:0] data_mask = 16'h0000;

  logic [22:0] exp_addr[$];
  logic [15:0] exp_word[$];

  function automatic logic [15:0] mem_word(input logic [22:0] a);
    return a[15:0] ^ data_mask;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // PSRAM model: returns mem_word(address) psram_lat cycles after read_req rises.
  initial begin
    int unsigned pcnt;
    pcnt = 0;
    bus.read_valid = 1'b0;
    bus.read_data  = 16'h0000;
    forever begin
      @(negedge clk);
      if (bus.read_valid) begin
        bus.read_valid = 1'b0;
        pcnt = 0;
      end else if (bus.read_req && !psram_mute) begin
        pcnt++;
        if (pcnt >= psram_lat) begin
          bus.read_valid = 1'b1;
          bus.read_data  = mem_word(bus.read_address);
          pcnt = 0;
        end
      end else begin
        pcnt = 0;
      end
    end
  end

  // UART model: busy for uart_dur cycles after each send_uart pulse.
  initial begin
    int unsigned tcnt;
    tcnt = 0;
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.send_uart) begin
        bus.tx_busy = 1'b1;
        tcnt = uart_dur;
      end else if (tcnt > 0) begin
        tcnt--;
        if (tcnt == 0) bus.tx_busy = 1'b0;
      end
    end
  end

  // Monitor: every new read and every frame pops the scoreboard.
  initial begin
    logic prev_req;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.read_req && !prev_req) begin
        if (exp_addr.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL read_unexpected: got address 0x%0h, expected no read", bus.read_address);
        end else begin
          chk("read_address", 32'(bus.read_address), 32'(exp_addr.pop_front()));
        end
      end
      prev_req = bus.read_req;
      if (bus.send_uart) begin
        send_cnt++;
        if (exp_word.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL send_unexpected: got word 0x%0h, expected no frame", bus.send_msg);
        end else begin
          chk("send_msg", 32'(bus.send_msg), 32'(exp_word.pop_front()));
        end
      end
      if (bus.done) done_cnt++;
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_read_req"},     32'(bus.read_req),     32'h0);
    chk({tag, "_read_address"}, 32'(bus.read_address), 32'h0);
    chk({tag, "_send_uart"},    32'(bus.send_uart),    32'h0);
    chk({tag, "_send_msg"},     32'(bus.send_msg),     32'h0);
    chk({tag, "_busy"},         32'(bus.busy),         32'h0);
    chk({tag, "_done"},         32'(bus.done),         32'h0);
    chk({tag, "_error"},        32'(bus.error),        32'h0);
    chk({tag, "_words_sent"},   32'(bus.words_sent),   32'h0);
  endtask

  // Expected reads/frames for a dump; abort_at > 0 stops after that many frames.
  task automatic push_expected(input logic [22:0] base, input int unsigned n_reads,
                               input int unsigned n_frames);
    logic [22:0] a;
    for (int i = 0; i < int'(n_reads); i++) begin
      a = base + 23'(i);
      exp_addr.push_back(a);
      if (i < int'(n_frames)) exp_word.push_back(mem_word(a));
    end
  endtask

  task automatic run_dump(input logic [22:0] base, input int unsigned cnt,
                          input int unsigned abort_at, input bit to_mode, input bit ign_start);
    int unsigned n_exp, sends0, dones0, rq_cycles;
    bit got;
    n_exp = to_mode ? 0 : ((abort_at != 0 && abort_at < cnt) ? abort_at : cnt);
    push_expected(base, to_mode ? ((cnt != 0) ? 1 : 0) : n_exp, n_exp);
    sends0 = send_cnt;
    dones0 = done_cnt;
    @(negedge clk);
    bus.base_address = base;
    bus.word_count   = CNT_W'(cnt);
    bus.start        = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("read_req_n1", 32'(bus.read_req), (cnt != 0) ? 32'h1 : 32'h0);
    rq_cycles = int'(bus.read_req);
    got = 1'b0;
    for (int c = 0; c < 20000 && !got; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk("busy_n2", 32'(bus.busy), 32'h1);
        if (cnt == 0) chk("done_n2_zero", 32'(bus.done), 32'h1);
      end
      bus.start = ign_start && (c == 5);
      if (ign_start && c == 5) bus.word_count = CNT_W'(7);
      rq_cycles += int'(bus.read_req);
      if (abort_at != 0 && (send_cnt - sends0) >= abort_at) bus.abort = 1'b1;
      if (bus.done) got = 1'b1;
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("done_seen", 32'(got), 32'h1);
    chk("words_sent", 32'(bus.words_sent), 32'(n_exp));
    chk("error", 32'(bus.error), 32'(to_mode));
    if (to_mode) chk("timeout_req_cycles", 32'(rq_cycles), 32'(RT));
    @(negedge clk);
    chk("busy_after_done", 32'(bus.busy), 32'h0);
    chk("done_width", 32'(bus.done), 32'h0);
    chk("done_count", 32'(done_cnt - dones0), 32'h1);
    chk("frame_count", 32'(send_cnt - sends0), 32'(n_exp));
    chk("addr_queue_left", 32'(exp_addr.size()), 32'h0);
    chk("word_queue_left", 32'(exp_word.size()), 32'h0);
    exp_addr.delete();
    exp_word.delete();
  endtask

  initial begin
    int unsigned s0;
    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.base_address = 23'h0;
    bus.word_count   = '0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;

    run_dump(23'h000100, 3, 0, 1'b0, 1'b0);
    run_dump(23'h7FFFFE, 4, 0, 1'b0, 1'b0);
    run_dump(23'h000040, 0, 0, 1'b0, 1'b0);

    psram_mute = 1'b1;
    run_dump(23'h001234, 5, 0, 1'b1, 1'b0);
    psram_mute = 1'b0;

    uart_dur = 8;
    run_dump(23'h000300, 10, 2, 1'b0, 1'b1);

    // Reset while the first frame of a dump is still on the wire.
    uart_dur = 20;
    push_expected(23'h000200, 3, 3);
    s0 = send_cnt;
    @(negedge clk);
    bus.base_address = 23'h000200;
    bus.word_count   = CNT_W'(3);
    bus.start        = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < 200 && send_cnt == s0; c++) @(negedge clk);
    chk("mid_frame_sent", 32'(send_cnt - s0), 32'h1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_values("midreset");
    exp_addr.delete();
    exp_word.delete();
    for (int c = 0; c < 200 && bus.tx_busy; c++) @(negedge clk);
    run_dump(23'h000500, 3, 0, 1'b0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      logic [22:0] b;
      if ($urandom_range(0, 2) == 0) b = 23'h7FFFFF - 23'($urandom_range(0, 3));
      else                           b = 23'($urandom);
      psram_lat = $urandom_range(2, 6);
      uart_dur  = $urandom_range(2, 12);
      data_mask = 16'($urandom);
      run_dump(b, $urandom_range(1, 5), 0, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
